multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
// - Main control FSM sequencing a multi-cycle RV32I datapath (shared instr/data memory, IR, ALUOut, PC regs).
// - Decodes op/funct fields. Drives every datapath strobe and mux select once per state.
// - Waits on a memory ready handshake. Flags illegal opcodes and memory timeouts.
// - Sits beside the datapath and replaces the combinational single-cycle control decoder.
// PARAMETERS
// - MEM_TIMEOUT  16  Cycles mem_ready may stay low in a memory-wait state before bus_err (>=2).
// - CNT_W        32  Width of the performance counters (used only with CTRL_PERF_CNT_EN).
// PORTS
// - clk          in   1  Clock, rising edge.
// - srst         in   1  Reset, asynchronous, active-high.
// - op           in   7  instr[6:0] from IR.
// - funct3       in   3  instr[14:12].
// - funct7b5     in   1  instr[30].
// - zero         in   1  ALU zero flag.
// - mem_ready    in   1  Memory access completes this cycle.
// - pc_write     out  1  PC register load enable.
// - adr_src      out  1  Memory address select: 0=PC, 1=ALUOut.
// - mem_write    out  1  Memory write strobe.
// - ir_write     out  1  IR and OldPC load enable.
// - result_src   out  2  00=ALUOut, 01=read data, 10=ALU result.
// - alu_src_a    out  2  00=PC, 01=OldPC, 10=RD1.
// - alu_src_b    out  2  00=RD2, 01=imm_ext, 10=const 4.
// - imm_src      out  2  00=I, 01=S, 10=B, 11=J.
// - alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
// - reg_write    out  1  Register file write enable.
// - illegal      out  1  One-cycle pulse on an undecodable opcode.
// - bus_err      out  1  Sticky memory-timeout flag.
// BEHAVIOUR
// - Outputs are Moore, decoded from state. imm_src is decoded from op only.
// - While srst=1: state=FETCH, wait_cnt=0, bus_err=0. All strobes are 0 and all selects are 00.
// - Unlisted outputs are 0 in every state.
// - FETCH
//   - adr_src=0, a=00, b=10, add, result_src=10.
//   - ir_write and pc_write are asserted only when mem_ready=1.
//   - Next: DECODE on mem_ready, else stay in FETCH.
// - DECODE: a=01, b=01, add (precomputes the branch target). Next by op:
//   - 0000011/0100011 -> MEMADR
//   - 0110011 -> EXEC_R
//   - 0010011 -> EXEC_I
//   - 1100011 -> BEQ
//   - 1101111 -> JAL
//   - other -> FETCH with illegal=1 for this cycle.
// - MEMADR: a=10, b=01, add. Next: MEMREAD if op[5]=0, else MEMWRITE.
// - MEMREAD: adr_src=1, result_src=00. Next: MEMWB on mem_ready, else stay.
// - MEMWB: result_src=01, reg_write=1. Next: FETCH.
// - MEMWRITE: adr_src=1, result_src=00, mem_write held at 1. Next: FETCH on mem_ready, else stay.
// - EXEC_R: a=10, b=00, ALU decode (alu_op=10). Next: ALUWB.
// - EXEC_I: a=10, b=01, ALU decode. Next: ALUWB.
// - ALUWB: result_src=00, reg_write=1. Next: FETCH.
// - JAL: a=01, b=10, add, result_src=00, pc_write=1. Next: ALUWB.
// - BEQ: a=10, b=00, sub, result_src=00, pc_write=zero. Next: FETCH.
// - HALT: all strobes 0. Left only by reset.
// - ALU decode:
//   - funct3 000 -> sub if op[5]&funct7b5, else add.
//   - 010 -> slt; 110 -> or; 111 -> and; other -> add.
// - Latency with zero-wait memory: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
// - Memory wait:
//   - wait_cnt counts consecutive mem_ready=0 cycles in FETCH/MEMREAD/MEMWRITE.
//   - wait_cnt clears on mem_ready or on a state change.
//   - At wait_cnt==MEM_TIMEOUT-1 with mem_ready=0: next state is HALT and bus_err is set.
//   - mem_ready=1 in that same cycle wins (normal transition, no error).
// - Reset mid-operation:
//   - Strobes drop asynchronously.
//   - A pending memory write is abandoned.
//   - The FSM restarts in FETCH on the first edge after release.
// CONFIGURATION
// - CTRL_PERF_CNT_EN defined:
//   - Adds outputs cycle_cnt[CNT_W] and instret_cnt[CNT_W]. Both reset to 0.
//   - cycle_cnt increments every non-reset cycle except in HALT.
//   - instret_cnt increments on entry to FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
//   - Both counters wrap modulo 2^CNT_W.
// - CTRL_PERF_CNT_EN undefined: no counter ports and no counter logic.
// STRUCTURE
// - Package riscv_ctrl_pkg holds:
//   - the state_t enum;
//   - opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL);
//   - ALU_ADD/SUB/AND/OR/SLT codes;
//   - SRCA_*/SRCB_*/RES_*/IMM_* select encodings.
// - Sub-module alu_decoder: combinational (alu_op, funct3, op5, funct7b5) -> alu_control.
// - FSM, wait counter and optional counters live in this module.
// TESTING
// - lw (op=0000011), mem_ready=1:
//   - states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH;
//   - reg_write=1 only in cycle 5, with result_src=01.
// - beq (op=1100011):
//   - zero=1 -> pc_write=1 and alu_control=001 in cycle 3;
//   - zero=0 -> pc_write stays 0; next state FETCH.
// - R-type funct3=000:
//   - funct7b5=1 -> alu_control=001 in EXEC_R;
//   - funct7b5=0 -> 000;
//   - addi (op=0010011) with funct7b5=1 -> 000.
// - sw with mem_ready low 3 cycles:
//   - mem_write=1 for 4 consecutive cycles, adr_src=1;
//   - FETCH follows the ready cycle.
// - mem_ready held low 16 cycles in FETCH (MEM_TIMEOUT=16):
//   - bus_err=1, HALT, all strobes 0;
//   - srst pulse returns the FSM to FETCH with bus_err=0.
// - op=0000000:
//   - illegal=1 for exactly the DECODE cycle, then FETCH;
//   - srst asserted mid-MEMWRITE drops mem_write within the same cycle.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Shared types and encodings for the multi-cycle RV32I control FSM:
//            state enum, opcodes, ALU codes and datapath mux select values.
// Revision : 1.0  initial release
// ============================================================================
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  // Opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ALU operation class requested by the FSM
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // Mux select encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends on the opcode alone, never on FSM state
  function automatic logic [1:0] imm_sel(input logic [6:0] opc);
    case (opc)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational ALU control decode from the FSM's ALU op class and
//            the instruction funct fields.
// Revision : 1.0  initial release
// ============================================================================
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // Map op class and funct fields to an ALU operation
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // Only register-register forms can subtract; addi ignores bit 30
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Purpose  : Main control FSM for a multi-cycle RV32I datapath. Moore-decoded
//            strobes/selects, memory ready handshake with timeout (sticky
//            bus_err, HALT), illegal-opcode pulse.
//            Optional macro CTRL_PERF_CNT_EN adds cycle_cnt / instret_cnt.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       illegal,
  output logic       bus_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int              WAIT_W   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
    $error("multicycle_ctrl_fsm: MEM_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  state_t             state;
  state_t             next_state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [1:0]         alu_op;
  logic [2:0]         alu_ctrl_dec;
  logic               mem_wait;
  logic               timeout;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_ctrl_dec)
  );

  // States that stall on the memory handshake, and the timeout condition
  assign mem_wait = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout  = mem_wait && !mem_ready && (wait_cnt == WAIT_MAX);

  // State, wait counter and sticky bus error
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (timeout) begin
        bus_err <= 1'b1;
      end
      if (mem_wait && !mem_ready && (next_state == state)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Next-state and per-state output decode; reset forces every output low
  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RD2;
    alu_op      = ALUOP_ADD;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    imm_src     = imm_sel(op);

    case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed as OldPC + imm
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXEC_R;
          OP_ITYPE:          next_state = S_EXEC_I;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default: begin
            next_state = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_FUNC;
        next_state = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNC;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        pc_write   = zero;
        next_state = S_FETCH;
      end
      S_HALT: begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase

    // A stuck memory wins over staying put; ready in the same cycle wins over this
    if (timeout) begin
      next_state = S_HALT;
    end

    alu_control = alu_ctrl_dec;

    // Outputs drop immediately on reset, abandoning any pending write
    if (srst) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      alu_control = 3'b000;
      reg_write   = 1'b0;
      illegal     = 1'b0;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Cycle and retired-instruction counters, wrapping naturally
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if ((next_state == S_FETCH) &&
          ((state == S_MEMWB) || (state == S_MEMWRITE) ||
           (state == S_ALUWB) || (state == S_BEQ))) begin
        instret_cnt <= instret_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Purpose  : Directed self-checking bench for multicycle_ctrl_fsm.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       srst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, bus_err;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .srst(srst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .reg_write(reg_write), .illegal(illegal),
    .bus_err(bus_err)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observed output vector, field order matches mk()
  logic [17:0] outs;
  assign outs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, imm_src, alu_control, reg_write, illegal, bus_err};

  function automatic logic [17:0] mk(input logic pcw, adr, mw, irw,
                                     input logic [1:0] res, a, b, imm,
                                     input logic [2:0] alu,
                                     input logic rw, ill, be);
    return {pcw, adr, mw, irw, res, a, b, imm, alu, rw, ill, be};
  endfunction

  // Hand-written expected patterns per state
  function automatic logic [17:0] e_fetch(input logic r, input logic [1:0] imm);
    return mk(r, 0, 0, r, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_decode(input logic [1:0] imm, input logic ill);
    return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, ill, 0);
  endfunction
  function automatic logic [17:0] e_memadr(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_memread(input logic [1:0] imm);
    return mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_memwb(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1, 0, 0);
  endfunction
  function automatic logic [17:0] e_memwrite(input logic [1:0] imm);
    return mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0, 0, 0);
  endfunction
  function automatic logic [17:0] e_aluwb(input logic [1:0] imm);
    return mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0, 0);
  endfunction

  task automatic test_reset();
    srst = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 18'h0) begin
        failures++;
        $display("FAIL reset cycle %0d: outs=%05h expected=%05h", i, outs, 18'h0);
      end
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    srst = 1'b0;
  endtask

  // Memory stuck in FETCH for 16 cycles, then HALT; reset recovers to a working lw
  task automatic test_timeout();
    logic [19:0] rows[$];
    op = 7'b0000011;
    for (int i = 0; i < 16; i++) rows.push_back({1'b0, 1'b0, e_fetch(1'b0, 2'b00)});
    rows.push_back({1'b1, 1'b0, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,1)});
    rows.push_back({1'b1, 1'b0, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,1)});
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL timeout cycle %0d: outs=%05h expected=%05h", i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
    srst = 1'b1;
    #1;
    checks++;
    if (outs !== 18'h0) begin
      failures++;
      $display("FAIL timeout_reset: outs=%05h expected=%05h", outs, 18'h0);
    end
    @(posedge clk); #1;
    srst = 1'b0;
    rows = '{ {1'b1, 1'b0, e_fetch(1'b1, 2'b00)}, {1'b1, 1'b0, e_decode(2'b00, 1'b0)},
              {1'b1, 1'b0, e_memadr(2'b00)},      {1'b1, 1'b0, e_memread(2'b00)},
              {1'b1, 1'b0, e_memwb(2'b00)} };
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL timeout_recover cycle %0d: outs=%05h expected=%05h", i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Ready arriving on the last allowed cycle wins over the timeout
  task automatic test_timeout_boundary();
    logic [19:0] rows[$];
    op = 7'b0000011;
    for (int i = 0; i < 15; i++) rows.push_back({1'b0, 1'b0, e_fetch(1'b0, 2'b00)});
    rows.push_back({1'b1, 1'b0, e_fetch(1'b1, 2'b00)});
    rows.push_back({1'b1, 1'b0, e_decode(2'b00, 1'b0)});
    rows.push_back({1'b1, 1'b0, e_memadr(2'b00)});
    rows.push_back({1'b1, 1'b0, e_memread(2'b00)});
    rows.push_back({1'b1, 1'b0, e_memwb(2'b00)});
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL boundary cycle %0d: outs=%05h expected=%05h", i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [19:0] rows[$];
    op = 7'b0000011;
    rows = '{ {1'b1, 1'b0, e_fetch(1'b1, 2'b00)}, {1'b1, 1'b0, e_decode(2'b00, 1'b0)},
              {1'b1, 1'b0, e_memadr(2'b00)},      {1'b1, 1'b0, e_memread(2'b00)},
              {1'b1, 1'b0, e_memwb(2'b00)},       {1'b0, 1'b0, e_fetch(1'b0, 2'b00)} };
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL lw cycle %0d: outs=%05h expected=%05h", i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    logic [19:0] rows[$];
    op = 7'b0100011;
    rows = '{ {1'b1, 1'b0, e_fetch(1'b1, 2'b01)}, {1'b1, 1'b0, e_decode(2'b01, 1'b0)},
              {1'b1, 1'b0, e_memadr(2'b01)},
              {1'b0, 1'b0, e_memwrite(2'b01)},    {1'b0, 1'b0, e_memwrite(2'b01)},
              {1'b0, 1'b0, e_memwrite(2'b01)},    {1'b1, 1'b0, e_memwrite(2'b01)},
              {1'b0, 1'b0, e_fetch(1'b0, 2'b01)} };
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL sw_wait cycle %0d: outs=%05h expected=%05h", i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq(input logic z);
    logic [19:0] rows[$];
    op = 7'b1100011;
    rows = '{ {1'b1, z, e_fetch(1'b1, 2'b10)}, {1'b1, z, e_decode(2'b10, 1'b0)},
              {1'b1, z, mk(z,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0,0)},
              {1'b0, z, e_fetch(1'b0, 2'b10)} };
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL beq zero=%0b cycle %0d: outs=%05h expected=%05h", z, i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // R/I-type ALU instruction; is_r selects RD2 vs immediate for operand B
  task automatic test_exec(input string name, input logic [6:0] opc, input logic [2:0] f3,
                           input logic f7, input logic is_r, input logic [2:0] alu);
    logic [19:0] rows[$];
    op = opc; funct3 = f3; funct7b5 = f7;
    rows = '{ {1'b1, 1'b0, e_fetch(1'b1, 2'b00)}, {1'b1, 1'b0, e_decode(2'b00, 1'b0)},
              {1'b1, 1'b0, mk(0,0,0,0,2'b00,2'b10,(is_r ? 2'b00 : 2'b01),2'b00,alu,0,0,0)},
              {1'b1, 1'b0, e_aluwb(2'b00)},       {1'b0, 1'b0, e_fetch(1'b0, 2'b00)} };
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL %s cycle %0d: outs=%05h expected=%05h", name, i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
    funct3 = 3'b000; funct7b5 = 1'b0;
  endtask

  task automatic test_jal();
    logic [19:0] rows[$];
    op = 7'b1101111;
    rows = '{ {1'b1, 1'b0, e_fetch(1'b1, 2'b11)}, {1'b1, 1'b0, e_decode(2'b11, 1'b0)},
              {1'b1, 1'b0, mk(1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0,0)},
              {1'b1, 1'b0, e_aluwb(2'b11)},       {1'b0, 1'b0, e_fetch(1'b0, 2'b11)} };
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL jal cycle %0d: outs=%05h expected=%05h", i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [19:0] rows[$];
    op = 7'b0000000;
    rows = '{ {1'b1, 1'b0, e_fetch(1'b1, 2'b00)}, {1'b1, 1'b0, e_decode(2'b00, 1'b1)},
              {1'b0, 1'b0, e_fetch(1'b0, 2'b00)}, {1'b0, 1'b0, e_fetch(1'b0, 2'b00)} };
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL illegal cycle %0d: outs=%05h expected=%05h", i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted mid-cycle while a store is stalled must drop mem_write at once
  task automatic test_reset_mid_write();
    logic [19:0] rows[$];
    op = 7'b0100011;
    rows = '{ {1'b1, 1'b0, e_fetch(1'b1, 2'b01)}, {1'b1, 1'b0, e_decode(2'b01, 1'b0)},
              {1'b1, 1'b0, e_memadr(2'b01)},      {1'b0, 1'b0, e_memwrite(2'b01)} };
    foreach (rows[i]) begin
      mem_ready = rows[i][19]; zero = rows[i][18];
      @(negedge clk);
      checks++;
      if (outs !== rows[i][17:0]) begin
        failures++;
        $display("FAIL midwrite cycle %0d: outs=%05h expected=%05h", i, outs, rows[i][17:0]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    #2;
    srst = 1'b1;
    #1;
    checks++;
    if (outs !== 18'h0) begin
      failures++;
      $display("FAIL midwrite_reset: outs=%05h expected=%05h", outs, 18'h0);
    end
    @(posedge clk); #1;
    srst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== e_fetch(1'b0, 2'b01)) begin
      failures++;
      $display("FAIL midwrite_restart: outs=%05h expected=%05h", outs, e_fetch(1'b0, 2'b01));
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_timeout_boundary();
    test_lw();
    test_sw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_exec("r_sub",  7'b0110011, 3'b000, 1'b1, 1'b1, 3'b001);
    test_exec("r_add",  7'b0110011, 3'b000, 1'b0, 1'b1, 3'b000);
    test_exec("r_and",  7'b0110011, 3'b111, 1'b0, 1'b1, 3'b010);
    test_exec("r_or",   7'b0110011, 3'b110, 1'b0, 1'b1, 3'b011);
    test_exec("addi",   7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000);
    test_exec("slti",   7'b0010011, 3'b010, 1'b0, 1'b0, 3'b101);
    test_jal();
    test_illegal();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
